// File: rtl/code_lock_ctrl.sv
// Four-digit code lock: buttons A (digit 0) and B (digit 1) shift digits into num;
// after four digits the entry is checked, opening the lock or counting toward a lockout.
module code_lock_ctrl #(
  parameter logic [3:0] CODE        = 4'b1011,
  parameter int         OPEN_CYCLES = 8,
  parameter int         LOCK_CYCLES = 16,
  parameter int         MAX_FAIL    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A,
  input  logic       B,
  output logic       out,
  output logic [3:0] num,
  output logic [2:0] cnt,
  output logic       locked,
  output logic [1:0] fail_cnt,
  output logic [2:0] fsm_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ENTRY   = 3'd1;
  localparam logic [2:0] CHECK   = 3'd2;
  localparam logic [2:0] OPEN    = 3'd3;
  localparam logic [2:0] LOCKOUT = 3'd4;

  localparam logic [7:0] OPEN_LOAD = 8'(OPEN_CYCLES - 1);
  localparam logic [7:0] LOCK_LOAD = 8'(LOCK_CYCLES - 1);
  localparam logic [2:0] MAX_WIDE  = 3'(MAX_FAIL);
  localparam logic [1:0] MAX_SAT   = 2'(MAX_FAIL);

  logic [2:0] state;
  logic [7:0] timer;
  logic       a_q;
  logic       b_q;
  logic       press_a;
  logic       press_b;
  logic       valid_press;
  logic [3:0] num_shift;
  logic [2:0] fail_next;

  assign press_a     = A & ~a_q;
  assign press_b     = B & ~b_q;
  // Simultaneous rising edges are ambiguous and therefore dropped.
  assign valid_press = press_a ^ press_b;
  assign num_shift   = {num[2:0], press_b};
  assign fail_next   = {1'b0, fail_cnt} + 3'd1;

  assign out       = (state == OPEN);
  assign locked    = (state == LOCKOUT);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    // Edge detectors track the buttons even in reset, so a held button is not a press.
    a_q <= A;
    b_q <= B;
    if (rst) begin
      state    <= IDLE;
      num      <= 4'd0;
      cnt      <= 3'd0;
      fail_cnt <= 2'd0;
      timer    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_press) begin
            num   <= num_shift;
            cnt   <= 3'd1;
            state <= ENTRY;
          end
        end
        ENTRY: begin
          if (valid_press) begin
            num <= num_shift;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd3) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (num == CODE) begin
            state    <= OPEN;
            fail_cnt <= 2'd0;
            timer    <= OPEN_LOAD;
          end else if (fail_next < MAX_WIDE) begin
            state    <= IDLE;
            fail_cnt <= fail_next[1:0];
            cnt      <= 3'd0;
          end else begin
            state    <= LOCKOUT;
            fail_cnt <= MAX_SAT;
            timer    <= LOCK_LOAD;
          end
        end
        OPEN: begin
          if (timer == 8'd0) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        LOCKOUT: begin
          if (timer == 8'd0) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            fail_cnt <= 2'd0;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: directed scenarios plus random code entries, checked each
// cycle against a digit-list / countdown reference model through an expected queue.
module tb_code_lock_ctrl;

  localparam logic [3:0] CODE        = 4'b1011;
  localparam int         OPEN_CYCLES = 8;
  localparam int         LOCK_CYCLES = 16;
  localparam int         MAX_FAIL    = 3;

  logic       clk;
  logic       rst;
  logic       A;
  logic       B;
  logic       out;
  logic [3:0] num;
  logic [2:0] cnt;
  logic       locked;
  logic [1:0] fail_cnt;
  logic [2:0] fsm_state;

  code_lock_ctrl #(
    .CODE(CODE), .OPEN_CYCLES(OPEN_CYCLES), .LOCK_CYCLES(LOCK_CYCLES), .MAX_FAIL(MAX_FAIL)
  ) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .out(out), .num(num), .cnt(cnt),
    .locked(locked), .fail_cnt(fail_cnt), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected word: {idle, out, locked, fail_cnt[1:0], cnt[2:0], num[3:0]}
  logic [11:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // reference model: digits entered, pending check, remaining open/lockout cycles
  int m_num, m_cnt, m_fails, m_open_left, m_lock_left;
  bit m_check_pending, m_prev_a, m_prev_b;

  task automatic model_edge(input bit a, input bit b, input bit r);
    bit pa, pb;
    pa = a && !m_prev_a;
    pb = b && !m_prev_b;
    if (r) begin
      m_num = 0; m_cnt = 0; m_fails = 0; m_open_left = 0; m_lock_left = 0;
      m_check_pending = 0;
    end else if (m_open_left > 0) begin
      m_open_left--;
      if (m_open_left == 0) m_cnt = 0;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) begin
        m_cnt = 0;
        m_fails = 0;
      end
    end else if (m_check_pending) begin
      m_check_pending = 0;
      if (m_num == int'(CODE)) begin
        m_open_left = OPEN_CYCLES;
        m_fails = 0;
      end else if (m_fails + 1 < MAX_FAIL) begin
        m_fails++;
        m_cnt = 0;
      end else begin
        m_lock_left = LOCK_CYCLES;
        m_fails = MAX_FAIL;
      end
    end else if (pa != pb) begin
      m_num = ((m_num * 2) + (pb ? 1 : 0)) % 16;
      m_cnt++;
      if (m_cnt == 4) m_check_pending = 1;
    end
    m_prev_a = a;
    m_prev_b = b;
  endtask

  function automatic logic [11:0] model_word();
    bit idle;
    idle = (m_open_left == 0) && (m_lock_left == 0) && !m_check_pending && (m_cnt == 0);
    return {idle, m_open_left > 0, m_lock_left > 0, 2'(m_fails), 3'(m_cnt), 4'(m_num)};
  endfunction

  // driver tasks
  task automatic step(input bit a, input bit b, input bit r);
    A = a; B = b; rst = r;
    @(posedge clk);
    model_edge(a, b, r);
    exp_q.push_back(model_word());
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic press(input bit d, input int gap);
    step(!d, d, 0);
    idle_cycles(gap);
  endtask

  task automatic enter_code(input logic [3:0] code, input int gap);
    for (int i = 3; i >= 0; i--) press(code[i], gap);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [11:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {fsm_state == 3'd0, out, locked, fail_cnt, cnt, num};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL cycle_check t=%0t got idle=%0b out=%0b locked=%0b fail_cnt=%0d cnt=%0d num=%b expected idle=%0b out=%0b locked=%0b fail_cnt=%0d cnt=%0d num=%b",
                 $time, g[11], g[10], g[9], g[8:7], g[6:4], g[3:0],
                 e[11], e[10], e[9], e[8:7], e[6:4], e[3:0]);
      end
    end
  end

  initial begin
    int drain;
    logic [3:0] code;
    A = 0; B = 0; rst = 1;
    m_prev_a = 0; m_prev_b = 0;
    m_num = 0; m_cnt = 0; m_fails = 0; m_open_left = 0; m_lock_left = 0; m_check_pending = 0;
    step(0, 0, 1);
    step(0, 0, 1);

    // correct entry B,A,B,B three cycles apart, then the open window
    enter_code(CODE, 2);
    idle_cycles(12);

    // three wrong entries into lockout, presses during lockout ignored
    for (int k = 0; k < 3; k++) enter_code(4'b0000, 1);
    enter_code(CODE, 1);
    idle_cycles(16);

    // simultaneous edges mid-entry at cnt=2, then single presses finish the entry
    press(1, 1);
    press(0, 1);
    step(1, 1, 0);
    idle_cycles(1);
    press(1, 1);
    press(1, 1);
    idle_cycles(4);

    // button A held for 10 cycles is one press
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    idle_cycles(2);
    press(0, 1); press(1, 1); press(1, 1);
    idle_cycles(4);

    // reset pulsed while open, with B held through reset release
    enter_code(CODE, 1);
    idle_cycles(4);
    step(0, 1, 0);
    step(0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    idle_cycles(2);

    // wrong entry followed by a correct one
    enter_code(4'b0110, 1);
    idle_cycles(2);
    enter_code(CODE, 1);
    idle_cycles(12);

    // random attempts with occasional glitches and resets
    for (int k = 0; k < 60; k++) begin
      code = ($urandom_range(0, 1) == 1) ? CODE : 4'($urandom_range(0, 15));
      for (int i = 3; i >= 0; i--) begin
        if ($urandom_range(0, 9) == 0) step(1, 1, 0);
        press(code[i], $urandom_range(1, 3));
        if ($urandom_range(0, 29) == 0) step(0, 0, 1);
      end
      for (int i = 0; i < $urandom_range(0, 20); i++)
        step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 0);
    end
    idle_cycles(20);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout left=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
